// File: rtl/tone_div_detect.sv
// tone_div_detect: recovers the divider value of an incoming square-wave tone.
// The tone is synchronized and each edge (rising or falling) is timestamped
// against a saturating counter. The counter value at an edge is the measurement
// (half-period minus 1). A run of STABLE_N matching measurements locks div_out.
// TIMEOUT cycles without an edge declares silence and drops lock.
// Optional macro DIV_TOL_EN: measurements within TOL of the candidate count as
// matching. Without it, exact equality is required.
module tone_div_detect #(
  parameter int CNT_W    = 32,
  parameter int STABLE_N = 4,
  parameter int TIMEOUT  = 2_000_000,
  parameter int TOL      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] div_out,
  output logic             div_valid,
  output logic             div_update,
  output logic             silence
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       STABLE_C  = 4'(STABLE_N);

  logic             sync1, sync2, prev;
  logic             tone_edge;
  logic             is_match;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] cand, cand_n;
  logic [3:0]       match_cnt, match_n;
  logic [CNT_W-1:0] div_out_n;
  logic             valid_n, update_n, silence_n;

  // Two-flop synchronizer plus a history flop for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign tone_edge = sync2 ^ prev;

`ifdef DIV_TOL_EN
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
  logic [CNT_W-1:0] diff;

  // Absolute difference without wrap: larger minus smaller.
  always_comb begin
    diff = (cnt >= cand) ? (cnt - cand) : (cand - cnt);
  end

  assign is_match = (diff <= TOL_C);
`else
  // TOL has no effect in exact-match mode; this keeps it referenced.
  logic unused_tol;
  assign unused_tol = ^TOL;

  assign is_match = (cnt == cand);
`endif

  // Next-state and next-output logic for counter, candidate tracking and lock.
  // NOTE: every variable gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cand_n    = cand;
    match_n   = match_cnt;
    div_out_n = div_out;
    valid_n   = div_valid;
    update_n  = 1'b0;
    silence_n = silence;

    if (tone_edge) begin
      // An edge wins over a coincident timeout; cnt is the measurement.
      cnt_n = '0;
      case (state)
        IDLE: begin
          // First edge only marks the start of a period.
          state_n = MEAS;
        end
        MEAS: begin
          silence_n = 1'b0;
          if (match_cnt == 4'd0 || !is_match) begin
            cand_n  = cnt;
            match_n = 4'd1;
          end else if (match_cnt != STABLE_C) begin
            match_n = match_cnt + 4'd1;
          end
          if (match_n == STABLE_C) begin
            div_out_n = cand_n;
            valid_n   = 1'b1;
            update_n  = 1'b1;
            state_n   = LOCK;
          end
        end
        LOCK: begin
          silence_n = 1'b0;
          if (!is_match) begin
            valid_n = 1'b0;
            cand_n  = cnt;
            match_n = 4'd1;
            state_n = MEAS;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else if (cnt == TIMEOUT_C) begin
      // No edge for TIMEOUT cycles: drop lock, keep the last div_out.
      silence_n = 1'b1;
      valid_n   = 1'b0;
      match_n   = 4'd0;
      state_n   = IDLE;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  // State and registered outputs.
  // NOTE: all of these are plain flops, so every one gets an async reset value;
  // silence starts high because no edge has been seen yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      match_cnt  <= 4'd0;
      div_out    <= '0;
      div_valid  <= 1'b0;
      div_update <= 1'b0;
      silence    <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cand       <= cand_n;
      match_cnt  <= match_n;
      div_out    <= div_out_n;
      div_valid  <= valid_n;
      div_update <= update_n;
      silence    <= silence_n;
    end
  end

endmodule

// File: tb/tb_tone_div_detect.sv
// tb_tone_div_detect: directed bench for tone_div_detect with a short TIMEOUT.
module tb_tone_div_detect;

  localparam int CNT_W    = 16;
  localparam int STABLE_N = 4;
  localparam int TIMEOUT  = 200;
  localparam int TOL      = 1;

  logic             clk;
  logic             rst;
  logic             tone_in;
  logic [CNT_W-1:0] div_out;
  logic             div_valid;
  logic             div_update;
  logic             silence;

  int total;
  int bad;
  int upd_cnt;
  int sil_cnt;
  int exp_upd;
  int sil_mark;

  tone_div_detect #(
    .CNT_W   (CNT_W),
    .STABLE_N(STABLE_N),
    .TIMEOUT (TIMEOUT),
    .TOL     (TOL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .div_out   (div_out),
    .div_valid (div_valid),
    .div_update(div_update),
    .silence   (silence)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with div_update high and cycles with silence high.
  always @(posedge clk) begin
    if (div_update === 1'b1) upd_cnt <= upd_cnt + 1;
    if (silence === 1'b1)    sil_cnt <= sil_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Toggle the tone, then hold it for n cycles (half-period n, divider n-1).
  task automatic half(input int n);
    tone_in = ~tone_in;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    upd_cnt = 0;
    sil_cnt = 0;
    exp_upd = 0;
    rst     = 1'b1;
    tone_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_div_out", 32'(div_out), 0);
    check("rst_valid", 32'(div_valid), 0);
    check("rst_update", 32'(div_update), 0);
    check("rst_silence", 32'(silence), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // div=9: four edges give three measurements, no lock yet
    repeat (4) half(10);
    check("d9_no_lock_valid", 32'(div_valid), 0);
    check("d9_no_lock_silence", 32'(silence), 0);
    check("d9_no_lock_upd", 32'(upd_cnt), 0);
    // fifth edge locks
    half(10);
    exp_upd = 1;
    check("d9_lock_valid", 32'(div_valid), 1);
    check("d9_lock_div", 32'(div_out), 9);
    check("d9_lock_silence", 32'(silence), 0);
    check("d9_lock_upd", 32'(upd_cnt), exp_upd);
    repeat (3) half(10);
    check("d9_hold_valid", 32'(div_valid), 1);
    check("d9_hold_upd", 32'(upd_cnt), exp_upd);

    // Switch to div=20: first 20-cycle measurement drops lock
    half(21);
    half(21);
    check("d20_drop_valid", 32'(div_valid), 0);
    check("d20_drop_div", 32'(div_out), 9);
    half(21);
    half(21);
    check("d20_pending_valid", 32'(div_valid), 0);
    half(21);
    exp_upd = 2;
    check("d20_lock_valid", 32'(div_valid), 1);
    check("d20_lock_div", 32'(div_out), 20);
    check("d20_lock_upd", 32'(upd_cnt), exp_upd);

    // Back to div=9, then hold the tone to reach timeout
    repeat (5) half(10);
    exp_upd = 3;
    check("d9b_lock_div", 32'(div_out), 9);
    check("d9b_lock_upd", 32'(upd_cnt), exp_upd);
    repeat (TIMEOUT + 3 - 10) @(negedge clk);
    check("to_before_silence", 32'(silence), 0);
    check("to_before_valid", 32'(div_valid), 1);
    @(negedge clk);
    check("to_silence", 32'(silence), 1);
    check("to_valid", 32'(div_valid), 0);
    check("to_div_hold", 32'(div_out), 9);

    // div=0: toggle every cycle
    repeat (5) half(1);
    repeat (3) @(negedge clk);
    exp_upd = 4;
    check("d0_lock_div", 32'(div_out), 0);
    check("d0_lock_valid", 32'(div_valid), 1);
    check("d0_lock_silence", 32'(silence), 0);
    check("d0_lock_upd", 32'(upd_cnt), exp_upd);

    // One-cycle reset while locked
    rst     = 1'b1;
    tone_in = 1'b0;
    #1;
    check("mid_rst_div", 32'(div_out), 0);
    check("mid_rst_valid", 32'(div_valid), 0);
    check("mid_rst_silence", 32'(silence), 1);
    check("mid_rst_update", 32'(div_update), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    half(3);
    check("post_rst_first_edge_silence", 32'(silence), 1);
    repeat (3) half(3);
    check("post_rst_4edges_valid", 32'(div_valid), 0);
    check("post_rst_4edges_silence", 32'(silence), 0);
    half(3);
    repeat (2) @(negedge clk);
    exp_upd = 5;
    check("post_rst_lock_valid", 32'(div_valid), 1);
    check("post_rst_lock_div", 32'(div_out), 2);
    check("post_rst_lock_upd", 32'(upd_cnt), exp_upd);

    // Measurements 15,16,14,15,15
    half(16);
    half(17);
    half(15);
    half(16);
    half(16);
    half(16);
`ifdef DIV_TOL_EN
    exp_upd = 6;
    check("tol_lock_valid", 32'(div_valid), 1);
    check("tol_lock_div", 32'(div_out), 15);
`else
    check("exact_no_lock_valid", 32'(div_valid), 0);
    check("exact_no_lock_div", 32'(div_out), 2);
`endif
    // Two more 15s: exact mode now has four consecutive equal measurements
    half(16);
    half(16);
    exp_upd = 6;
    check("m15_lock_valid", 32'(div_valid), 1);
    check("m15_lock_div", 32'(div_out), 15);
    check("m15_lock_upd", 32'(upd_cnt), exp_upd);

    // Edges landing exactly when cnt reaches TIMEOUT
    sil_mark = sil_cnt;
    repeat (5) half(TIMEOUT + 1);
    exp_upd = 7;
    check("edge_at_to_no_silence", 32'(sil_cnt - sil_mark), 0);
    check("edge_at_to_valid", 32'(div_valid), 1);
    check("edge_at_to_div", 32'(div_out), TIMEOUT);
    check("edge_at_to_upd", 32'(upd_cnt), exp_upd);
    repeat (3) @(negedge clk);
    check("final_silence", 32'(silence), 1);
    check("final_valid", 32'(div_valid), 0);
    check("final_div_hold", 32'(div_out), TIMEOUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
